// File: rtl/led7s_scan_decoder.sv
// led7s_scan_decoder: recovers hex nibbles from a multiplexed 7-segment bus with dwell filtering and staleness.
module led7s_scan_decoder #(
  parameter int N_DIGITS      = 4,
  parameter int STABLE_CYCLES = 3,
  parameter int TIMEOUT       = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [6:0]            seg,
  input  logic [N_DIGITS-1:0]   dig_sel,
  output logic [4*N_DIGITS-1:0] digits,
  output logic [N_DIGITS-1:0]   dig_valid,
  output logic [N_DIGITS-1:0]   dig_err,
  output logic                  upd,
  output logic [2:0]            upd_idx,
  output logic                  frame_done,
  output logic                  stale
);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [3:0] STB = 4'(STABLE_CYCLES);
  localparam logic [TW-1:0] TO = TW'(TIMEOUT);
  typedef enum logic [1:0] {IDLE, TRACK, CAPTURED} state_t;
  state_t              r_st;
  logic [6:0]          r_seg, r_seg_p;
  logic [N_DIGITS-1:0] r_sel, r_sel_p, r_seen;
  logic [3:0]          r_cnt, w_cnt;
  logic [TW-1:0]       r_to;
  logic                w_oh, w_chg, w_cap, w_full, w_hit, w_blank;
  logic [3:0]          w_nib;
  logic [2:0]          w_idx;
  // w_cnt is the dwell length including the sample currently held in r_seg/r_sel
  always_comb begin
    w_oh    = $onehot(r_sel);
    w_chg   = (r_sel != r_sel_p) || (r_seg != r_seg_p);
    w_cnt   = !w_oh ? 4'd0 : (w_chg || r_cnt == 4'd0) ? 4'd1 : (r_cnt == STB) ? STB : r_cnt + 4'd1;
    w_cap   = w_oh && (w_cnt == STB) && (r_st != CAPTURED || w_chg);
    w_full  = (r_seen | r_sel) == {N_DIGITS{1'b1}};
    w_blank = r_seg == 7'h00;
    w_idx   = 3'd0;
    for (int i = 0; i < N_DIGITS; i++)
      if (r_sel[i]) w_idx = w_idx | 3'(i);
  end
  always_comb begin
    w_nib = 4'h0;
    w_hit = 1'b1;
    case (r_seg)
      7'h3F: w_nib = 4'h0;
      7'h06: w_nib = 4'h1;
      7'h5B: w_nib = 4'h2;
      7'h4F: w_nib = 4'h3;
      7'h66: w_nib = 4'h4;
      7'h6D: w_nib = 4'h5;
      7'h7D: w_nib = 4'h6;
      7'h07: w_nib = 4'h7;
      7'h7F: w_nib = 4'h8;
      7'h6F: w_nib = 4'h9;
      7'h77: w_nib = 4'hA;
      7'h7C: w_nib = 4'hB;
      7'h39: w_nib = 4'hC;
      7'h5E: w_nib = 4'hD;
      7'h79: w_nib = 4'hE;
      7'h71: w_nib = 4'hF;
      default: w_hit = 1'b0;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_st       <= IDLE;
      r_seg      <= '0;
      r_seg_p    <= '0;
      r_sel      <= '0;
      r_sel_p    <= '0;
      r_seen     <= '0;
      r_cnt      <= '0;
      r_to       <= '0;
      digits     <= '0;
      dig_valid  <= '0;
      dig_err    <= '0;
      upd        <= 1'b0;
      upd_idx    <= '0;
      frame_done <= 1'b0;
      stale      <= 1'b0;
    end else begin
      r_seg      <= seg;
      r_sel      <= dig_sel;
      r_seg_p    <= r_seg;
      r_sel_p    <= r_sel;
      r_cnt      <= w_cnt;
      r_st       <= !w_oh ? IDLE : w_cap ? CAPTURED : (r_st == CAPTURED && !w_chg) ? CAPTURED : TRACK;
      upd        <= w_cap;
      upd_idx    <= w_cap ? w_idx : 3'd0;
      frame_done <= w_cap && w_full;
      if (w_cap) begin
        r_to   <= '0;
        stale  <= 1'b0;
        r_seen <= w_full ? '0 : (r_seen | r_sel);
        for (int i = 0; i < N_DIGITS; i++)
          if (r_sel[i]) begin
            dig_valid[i] <= w_hit;
            dig_err[i]   <= !w_hit && !w_blank;
            if (w_hit) digits[4*i +: 4] <= w_nib;
          end
      end else if (r_to != TO) begin
        r_to <= r_to + TW'(1);
        if (r_to == TO - TW'(1)) begin
          stale     <= 1'b1;
          dig_valid <= '0;
          r_seen    <= '0;
        end
      end
    end
  end
endmodule
